// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and helpers for the bit-serial subtractor
//
// Purpose : FSM state encoding and the counter-width helper used by
//           serial_subtractor.
// Ports   : none (package).

package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed for a counter that must reach w-1. The result is never below 1,
  // so that a 1-bit counter still exists for the smallest width.
  function automatic int count_width(input int w);
    if (w <= 2) begin
      return 1;
    end
    return $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit combinational full subtractor cell
//
// Purpose : d = x - y - bi (one bit), with borrow-out bo.
// Ports   : x  in  minuend bit
//           y  in  subtrahend bit
//           bi in  borrow-in
//           d  out difference bit
//           bo out borrow-out

module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  // Borrow when y exceeds x outright, or when x==y and a borrow is coming in.
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial N-bit subtractor, LSB first
//
// Purpose : diff = a - b - bin, one bit per clock through a single
//           full_subtractor cell and a registered borrow.
// Params  : WIDTH  operand/result width, 2..32
// Ports   : clk    in   rising-edge clock
//           rst_n  in   asynchronous active-low reset
//           start  in   request, sampled only in IDLE
//           a      in   minuend, captured on accept
//           b      in   subtrahend, captured on accept
//           bin    in   borrow-in, captured on accept
//           busy   out  high while bits are processed
//           done   out  one-cycle pulse, results valid from this cycle
//           diff   out  a - b - bin mod 2^WIDTH
//           bout   out  unsigned borrow-out
//           ovf    out  signed overflow (only with SERIAL_SUB_OVF_EN)
// Config  : define SERIAL_SUB_OVF_EN to add the ovf port and its logic.

module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = count_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             br;
  logic [CW-1:0]    count;
  logic             x;
  logic             y;
  logic             d;
  logic             bo;
  logic             last;

  assign x    = sa[0];
  assign y    = sb[0];
  assign last = (count == CW'(WIDTH - 1));

  full_subtractor u_fs (
    .x  (x),
    .y  (y),
    .bi (br),
    .d  (d),
    .bo (bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operands shift right so the current bit is always at position 0; the
  // result enters at the MSB so that after WIDTH shifts it is fully aligned.
  // On the last bit sa[0]/sb[0] are the original operand MSBs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      br    <= 1'b0;
      count <= '0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            count <= '0;
          end
        end
        SHIFT: begin
          diff  <= {d, diff[WIDTH-1:1]};
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          br    <= bo;
          count <= count + CW'(1);
          if (last) begin
            bout <= bo;
`ifdef SERIAL_SUB_OVF_EN
            // Operands of differing sign whose result sign differs from the
            // minuend's cannot be represented.
            ovf  <= (x ^ y) & (d ^ x);
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor

module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
`ifdef SERIAL_SUB_OVF_EN
    .ovf   (ovf),
`endif
    .diff  (diff),
    .bout  (bout)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: timeline of one op is accept edge, W busy cycles, one
  // done cycle, then idle. Results come from integer arithmetic.
  int           m_phase = 0;
  logic [W-1:0] m_diff = '0;
  logic         m_bout = 1'b0;
  logic [W-1:0] p_diff = '0;
  logic         p_bout = 1'b0;
  int           t_u;
`ifdef SERIAL_SUB_OVF_EN
  logic         m_ovf = 1'b0;
  logic         p_ovf = 1'b0;
  int           t_s;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_diff  <= '0;
      m_bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      m_ovf   <= 1'b0;
`endif
    end else if (m_phase == 0) begin
      if (start) begin
        t_u = int'(a) - int'(b) - int'(bin);
        p_diff  <= t_u[W-1:0];
        p_bout  <= (t_u < 0);
`ifdef SERIAL_SUB_OVF_EN
        t_s = int'($signed(a)) - int'($signed(b)) - int'(bin);
        p_ovf   <= (t_s < -(1 << (W-1))) || (t_s > (1 << (W-1)) - 1);
`endif
        m_phase <= 1;
      end
    end else if (m_phase <= W) begin
      m_phase <= m_phase + 1;
      if (m_phase == W) begin
        m_diff <= p_diff;
        m_bout <= p_bout;
`ifdef SERIAL_SUB_OVF_EN
        m_ovf  <= p_ovf;
`endif
      end
    end else begin
      m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= W));
      check("done", 32'(done), 32'(m_phase == W + 1));
      if (m_phase == 0 || m_phase == W + 1) begin
        check("diff", 32'(diff), 32'(m_diff));
        check("bout", 32'(bout), 32'(m_bout));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", 32'(ovf), 32'(m_ovf));
`endif
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after done.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tbin, input bit inject,
                        output logic [W-1:0] rd, output logic rb,
                        output int cyc, output int bcnt);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    cyc = 0; bcnt = 0;
    while (!done && cyc < 50) begin
      if (busy) bcnt++;
      if (inject && cyc == 3) begin
        start = 1'b1; a = 8'hAA;
      end else if (inject && cyc == 4) begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 32'(done), 32'd1);
    rd = diff; rb = bout;
    @(negedge clk);
  endtask

  logic [W-1:0] rd;
  logic         rb;
  int           cyc;
  int           bcnt;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    run_op(8'd5, 8'd3, 1'b0, 1'b0, rd, rb, cyc, bcnt);
    check("d1_diff", 32'(rd), 32'h02);
    check("d1_bout", 32'(rb), 32'd0);
    check("d1_latency", 32'(cyc), 32'd8);
    check("d1_busy_cycles", 32'(bcnt), 32'd8);

    run_op(8'd3, 8'd5, 1'b0, 1'b0, rd, rb, cyc, bcnt);
    check("d2_diff", 32'(rd), 32'hFE);
    check("d2_bout", 32'(rb), 32'd1);

    run_op(8'd0, 8'd0, 1'b1, 1'b0, rd, rb, cyc, bcnt);
    check("d3_diff", 32'(rd), 32'hFF);
    check("d3_bout", 32'(rb), 32'd1);

    run_op(8'd5, 8'd3, 1'b0, 1'b1, rd, rb, cyc, bcnt);
    check("ign_diff", 32'(rd), 32'h02);
    check("ign_latency", 32'(cyc), 32'd8);
    run_op(8'h12, 8'h34, 1'b1, 1'b0, rd, rb, cyc, bcnt);
    check("second_diff", 32'(rd), 32'hDD);
    check("second_bout", 32'(rb), 32'd1);

    // Reset in the middle of an op.
    a = 8'h77; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'h40, 8'h01, 1'b0, 1'b0, rd, rb, cyc, bcnt);
    check("post_rst_diff", 32'(rd), 32'h3F);
    check("post_rst_bout", 32'(rb), 32'd0);

`ifdef SERIAL_SUB_OVF_EN
    run_op(8'h80, 8'h01, 1'b0, 1'b0, rd, rb, cyc, bcnt);
    check("ovf1_diff", 32'(rd), 32'h7F);
    check("ovf1_bout", 32'(rb), 32'd0);
    check("ovf1_ovf", 32'(ovf), 32'd1);
    run_op(8'h10, 8'h01, 1'b0, 1'b0, rd, rb, cyc, bcnt);
    check("ovf0_diff", 32'(rd), 32'h0F);
    check("ovf0_ovf", 32'(ovf), 32'd0);
`endif

    // Random traffic: start may be held, pulsed while busy, or arrive in DONE.
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 3) == 0);
      a     = W'($urandom);
      b     = W'($urandom);
      bin   = 1'($urandom);
      if ((i % 128) < 4) begin
        a = 8'h00; b = 8'hFF;
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
